// File: rtl/ps2_alu_sequencer_if.sv
// Keyboard-side lines plus the operand/operator bus presented to the ALU and display.
// The keyboard owns PS2_CLK/PS2_DATA; the sequencer owns every other signal.
interface ps2_alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             PS2_CLK;
  logic             PS2_DATA;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [1:0]       op_out;
  logic             alu_go;
  logic [2:0]       state_out;
  logic             frame_err;

  modport master (
    output PS2_CLK, PS2_DATA,
    input  a_out, b_out, op_out, alu_go, state_out, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output a_out, b_out, op_out, alu_go, state_out, frame_err
  );
endinterface

// File: rtl/ps2_alu_sequencer.sv
// PS/2 receiver and A/op/B/Enter entry FSM; alu_go lands two cycles after the stop-bit edge is seen.
// No backpressure: keys are acted on once. Macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_alu_sequencer #(
  parameter int WIDTH       = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int SYNC_STAGES = 2
) (
  input logic                CLK100MHZ,
  input logic                reset,
  ps2_alu_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   ps2_bit;
  logic [3:0]             bitcnt;
  logic [8:0]             shreg;
  logic [TW-1:0]          tcnt;
  logic                   par_ok;
  logic                   key_vld;
  logic [7:0]             key_dat;
  logic                   frame_err;
  logic                   brk;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [1:0]       op_q, op_nxt;
  logic             go_q, go_nxt;

  logic             act, is_digit, is_op, is_enter, is_esc;
  logic [3:0]       digit;
  logic [1:0]       op_code;

  // Lines idle high, so resetting the synchronisers high avoids a phantom edge.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.PS2_DATA};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_bit = dat_sync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge CLK100MHZ) begin
    if (reset)
      par_bit <= 1'b0;
    else if (fall && bitcnt == 4'd9)
      par_bit <= ps2_bit;
  end
  assign par_ok = ^{shreg[8:1], par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // shreg collects start + D0..D7 (start ends in bit 0); the stop bit is checked live.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      bitcnt    <= 4'd0;
      shreg     <= 9'd0;
      tcnt      <= '0;
      key_vld   <= 1'b0;
      key_dat   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      key_vld   <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt <= 4'd0;
          if (!shreg[0] && ps2_bit && par_ok) begin
            key_vld <= 1'b1;
            key_dat <= shreg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          if (bitcnt <= 4'd8)
            shreg <= {ps2_bit, shreg[8:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          bitcnt    <= 4'd0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // E0 needs no state: it decodes as an unmapped byte, and its follower maps as plain.
  always_ff @(posedge CLK100MHZ) begin
    if (reset)
      brk <= 1'b0;
    else if (key_vld)
      brk <= brk ? 1'b0 : (key_dat == 8'hF0);
  end

  assign act = key_vld & ~brk;

  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    is_op    = 1'b0;
    op_code  = 2'b00;
    is_enter = 1'b0;
    is_esc   = 1'b0;
    case (key_dat)
      8'h45: begin is_digit = 1'b1; digit = 4'd0; end
      8'h16: begin is_digit = 1'b1; digit = 4'd1; end
      8'h1E: begin is_digit = 1'b1; digit = 4'd2; end
      8'h26: begin is_digit = 1'b1; digit = 4'd3; end
      8'h25: begin is_digit = 1'b1; digit = 4'd4; end
      8'h2E: begin is_digit = 1'b1; digit = 4'd5; end
      8'h36: begin is_digit = 1'b1; digit = 4'd6; end
      8'h3D: begin is_digit = 1'b1; digit = 4'd7; end
      8'h3E: begin is_digit = 1'b1; digit = 4'd8; end
      8'h46: begin is_digit = 1'b1; digit = 4'd9; end
      8'h79: begin is_op = 1'b1; op_code = 2'b00; end
      8'h7B: begin is_op = 1'b1; op_code = 2'b01; end
      8'h31: begin is_op = 1'b1; op_code = 2'b10; end
      8'h44: begin is_op = 1'b1; op_code = 2'b11; end
      8'h5A: is_enter = 1'b1;
      8'h76: is_esc   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= S_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 2'b00;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
      go_q  <= go_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    go_nxt    = 1'b0;
    if (act) begin
      if (is_esc) begin
        a_nxt     = '0;
        b_nxt     = '0;
        op_nxt    = 2'b00;
        state_nxt = S_A;
      end else begin
        case (state)
          S_A: if (is_digit) begin
            a_nxt     = WIDTH'(digit);
            state_nxt = S_OP;
          end
          S_OP: if (is_digit) begin
            a_nxt = WIDTH'(digit);
          end else if (is_op) begin
            op_nxt    = op_code;
            state_nxt = S_B;
          end
          S_B: if (is_digit) begin
            b_nxt     = WIDTH'(digit);
            state_nxt = S_EQ;
          end else if (is_op) begin
            op_nxt = op_code;
          end
          S_EQ: if (is_enter) begin
            go_nxt    = 1'b1;
            state_nxt = S_DONE;
          end else if (is_digit) begin
            b_nxt = WIDTH'(digit);
          end
          S_DONE: if (is_digit) begin
            a_nxt     = WIDTH'(digit);
            b_nxt     = '0;
            state_nxt = S_OP;
          end else if (is_enter) begin
            go_nxt = 1'b1;
          end
          default: state_nxt = S_A;
        endcase
      end
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_out    = op_q;
  assign bus.alu_go    = go_q;
  assign bus.state_out = state;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ps2_alu_sequencer.sv
// Directed + randomized key frames against a keystroke-level model of the entry rules.
module tb_ps2_alu_sequencer;
  localparam int WIDTH = 4;
  localparam int TOUT  = 200;
  localparam int HP    = 20;
  localparam int IDLE  = 12;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  ps2_alu_sequencer #(
    .WIDTH(WIDTH),
    .TIMEOUT_CYC(TOUT),
    .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int go_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (bus.alu_go === 1'b1) go_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  byte unsigned digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  byte unsigned ops [4] = '{8'h79, 8'h7B, 8'h31, 8'h44};

  // Model: which entry phase we are in (0=A .. 4=DONE) and the latched operands.
  int m_state, m_a, m_b, m_op;
  bit m_brk;

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] c, output int go);
    int d, o;
    go = 0;
    if (m_brk) begin m_brk = 1'b0; return; end
    if (c == 8'hF0) begin m_brk = 1'b1; return; end
    if (c == 8'hE0) return;
    d = -1; o = -1;
    for (int i = 0; i < 10; i++) if (digits[i] == c) d = i;
    for (int i = 0; i < 4; i++) if (ops[i] == c) o = i;
    if (c == 8'h76) begin
      m_a = 0; m_b = 0; m_op = 0; m_state = 0;
      return;
    end
    case (m_state)
      0: if (d >= 0) begin m_a = d; m_state = 1; end
      1: if (d >= 0) m_a = d;
         else if (o >= 0) begin m_op = o; m_state = 2; end
      2: if (d >= 0) begin m_b = d; m_state = 3; end
         else if (o >= 0) m_op = o;
      3: if (c == 8'h5A) begin go = 1; m_state = 4; end
         else if (d >= 0) m_b = d;
      4: if (d >= 0) begin m_a = d; m_b = 0; m_state = 1; end
         else if (c == 8'h5A) go = 1;
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^c) ^ bad_par;
    return {~bad_stop, p, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.PS2_DATA = bits[i];
      repeat (HP) @(posedge clk);
      bus.PS2_CLK = 1'b0;
      repeat (HP) @(posedge clk);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DATA = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".a"}, 32'(bus.a_out), 32'(m_a));
    chk({tag, ".b"}, 32'(bus.b_out), 32'(m_b));
    chk({tag, ".op"}, 32'(bus.op_out), 32'(m_op));
    chk({tag, ".state"}, 32'(bus.state_out), 32'(m_state));
  endtask

  task automatic key(input string tag, input logic [7:0] c, input bit bad_par, input bit bad_stop);
    int g0, e0, eg, ee;
    g0 = go_cnt; e0 = err_cnt; eg = 0; ee = 0;
    send_bits(mkframe(c, bad_par, bad_stop), 11);
    repeat (IDLE) @(posedge clk);
    @(negedge clk);
    if (bad_stop || (bad_par && PAR_EN)) ee = 1;
    else model_byte(c, eg);
    chk({tag, ".go"}, 32'(go_cnt - g0), 32'(eg));
    chk({tag, ".err"}, 32'(err_cnt - e0), 32'(ee));
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset_hold");
    chk("reset_hold.go", 32'(bus.alu_go), 32'd0);
    chk("reset_hold.err", 32'(bus.frame_err), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int e0, r;
    logic [7:0] c;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DATA = 1'b1;
    model_reset();

    do_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_reset.err_cnt", 32'(err_cnt), 32'd0);
    chk("post_reset.go_cnt", 32'(go_cnt), 32'd0);

    // Full expression: 1 + 3 = enter
    key("s2_1", 8'h16, 0, 0);
    key("s2_add", 8'h79, 0, 0);
    key("s2_3", 8'h26, 0, 0);
    key("s2_ent", 8'h5A, 0, 0);
    chk("s2_final.state", 32'(bus.state_out), 32'd4);

    // Back into S_EQ, then a break code and keypad Enter
    key("s3_1", 8'h16, 0, 0);
    key("s3_add", 8'h79, 0, 0);
    key("s3_3", 8'h26, 0, 0);
    key("s3_brk", 8'hF0, 0, 0);
    key("s3_rel", 8'h26, 0, 0);
    chk("s3_eq.state", 32'(bus.state_out), 32'd3);
    key("s3_ext", 8'hE0, 0, 0);
    key("s3_kpent", 8'h5A, 0, 0);

    // Digit 2 with wrong parity
    key("s4_badpar", 8'h1E, 1, 0);

    // Truncated frame followed by a timeout, then a clean 0
    e0 = err_cnt;
    send_bits(mkframe(8'h45, 0, 0), 5);
    repeat (TOUT * 5 / 2) @(posedge clk);
    @(negedge clk);
    chk("s5_timeout.err", 32'(err_cnt - e0), 32'd1);
    key("s5_0", 8'h45, 0, 0);
    chk("s5_final.state", 32'(bus.state_out), 32'd1);

    // Bad stop bit dropped
    key("badstop", 8'h26, 0, 1);

    // Escape clears everything
    key("s6_1", 8'h16, 0, 0);
    key("s6_sub", 8'h7B, 0, 0);
    key("s6_esc", 8'h76, 0, 0);

    // Reset in the middle of a frame
    send_bits(mkframe(8'h26, 0, 0), 4);
    do_reset();
    key("midreset_1", 8'h16, 0, 0);

    // Randomized keystrokes
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      c = digits[$urandom_range(0, 9)];
      else if (r < 55) c = ops[$urandom_range(0, 3)];
      else if (r < 70) c = 8'h5A;
      else if (r < 75) c = 8'h76;
      else if (r < 83) c = 8'hF0;
      else if (r < 90) c = 8'hE0;
      else             c = 8'($urandom_range(0, 255));
      key($sformatf("rnd%0d", k), c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
